// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues one instruction fetch at a time, applies
// branch/JALR redirects and parks in a trap state on misaligned fetch targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        flush,
    output logic        misalign_trap,
    input  logic        trap_ack
);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_TRAP     = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pend_target, w_pend_target_nxt;
    logic        r_pend_valid, w_pend_valid_nxt;
    logic        r_req_sent, w_req_sent_nxt;
    logic        r_flush, w_flush_nxt;
    logic        r_trap;
    logic        w_req_valid;
    logic        w_redir_hit;
    logic [31:0] w_redir_target;
    logic [31:0] w_next_pc;
    logic        w_next_is_redir;

    // Decode this cycle's redirect; JALR wins over a taken branch.
    always_comb begin
        w_redir_hit    = 1'b0;
        w_redir_target = 32'h0000_0000;
        if (jalr_valid) begin
            w_redir_hit    = 1'b1;
            w_redir_target = jalr_target & 32'hFFFF_FFFE;
        end else if (br_valid && br_taken) begin
            w_redir_hit    = 1'b1;
            w_redir_target = br_pc + br_imm;
        end else begin
            w_redir_hit    = 1'b0;
            w_redir_target = 32'h0000_0000;
        end
    end

    // Next fetch address: same-cycle redirect, then pending redirect, then sequential.
    always_comb begin
        w_next_pc       = r_pc + PC_STEP;
        w_next_is_redir = 1'b0;
        if (w_redir_hit) begin
            w_next_pc       = w_redir_target;
            w_next_is_redir = 1'b1;
        end else if (r_pend_valid) begin
            w_next_pc       = r_pend_target;
            w_next_is_redir = 1'b1;
        end else begin
            w_next_pc       = r_pc + PC_STEP;
            w_next_is_redir = 1'b0;
        end
    end

    // Sequencer next-state, PC update, redirect latching and request generation.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_req_sent_nxt    = r_req_sent;
        w_flush_nxt       = 1'b0;
        w_req_valid       = 1'b0;

        if ((r_state != S_TRAP) && w_redir_hit) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = w_redir_target;
        end else begin
            w_pend_valid_nxt  = r_pend_valid;
            w_pend_target_nxt = r_pend_target;
        end

        case (r_state)
            S_BOOT: begin
                w_state_nxt    = S_ISSUE;
                w_req_sent_nxt = 1'b0;
            end
            S_ISSUE: begin
                // Once offered, the request stays up until accepted, whatever stall does.
                w_req_valid = !stall || r_req_sent;
                if (w_req_valid && imem_req_ready) begin
                    w_state_nxt    = S_WAIT_RSP;
                    w_req_sent_nxt = 1'b0;
                end else if (w_req_valid) begin
                    w_req_sent_nxt = 1'b1;
                end else begin
                    w_req_sent_nxt = r_req_sent;
                end
            end
            S_WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    w_pend_valid_nxt = 1'b0;
                    if (w_next_pc[1:0] != 2'b00) begin
                        w_state_nxt = S_TRAP;
                    end else begin
                        w_pc_nxt    = w_next_pc;
                        w_flush_nxt = w_next_is_redir;
                        w_state_nxt = S_ISSUE;
                    end
                end else begin
                    w_state_nxt = S_WAIT_RSP;
                end
            end
            S_TRAP: begin
                if (trap_ack) begin
                    w_pc_nxt         = TRAP_VEC;
                    w_flush_nxt      = 1'b1;
                    w_pend_valid_nxt = 1'b0;
                    w_state_nxt      = S_ISSUE;
                end else begin
                    w_state_nxt = S_TRAP;
                end
            end
            default: begin
                w_state_nxt      = S_BOOT;
                w_pend_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, PC, pending redirect and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0000_0000;
            r_req_sent    <= 1'b0;
            r_flush       <= 1'b0;
            r_trap        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_req_sent    <= w_req_sent_nxt;
            r_flush       <= w_flush_nxt;
            r_trap        <= (w_state_nxt == S_TRAP);
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign flush          = r_flush;
    assign misalign_trap  = r_trap;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized fetches,
// checked against a transaction-level model of the fetch/redirect/trap rules.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc = 32'h0;
    logic [31:0] br_imm = 32'h0;
    logic        jalr_valid = 1'b0;
    logic [31:0] jalr_target = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] pc;
    logic        flush;
    logic        misalign_trap;
    logic        trap_ack = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_pc;
    bit          m_pend_v;
    logic [31:0] m_pend_t;
    logic [31:0] g_br_pc, g_br_imm, g_jt;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm),
        .jalr_valid(jalr_valid), .jalr_target(jalr_target), .stall(stall),
        .pc(pc), .flush(flush), .misalign_trap(misalign_trap), .trap_ack(trap_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // kind: 0 none, 1 taken branch, 2 not-taken branch, 3 jalr, 4 jalr + taken branch
    task automatic drive_redir(input int kind);
        br_valid    = (kind == 1 || kind == 2 || kind == 4);
        br_taken    = (kind == 1 || kind == 4);
        jalr_valid  = (kind == 3 || kind == 4);
        br_pc       = g_br_pc;
        br_imm      = g_br_imm;
        jalr_target = g_jt;
    endtask

    task automatic clear_redir();
        br_valid   = 1'b0;
        br_taken   = 1'b0;
        jalr_valid = 1'b0;
    endtask

    task automatic redir_tgt(input int kind, output bit hit, output logic [31:0] t);
        hit = 1'b0;
        t   = 32'h0;
        if (kind == 3 || kind == 4) begin
            hit = 1'b1;
            t   = g_jt & 32'hFFFF_FFFE;
        end else if (kind == 1) begin
            hit = 1'b1;
            t   = g_br_pc + g_br_imm;
        end
    endtask

    task automatic capture(input int kind);
        bit          hit;
        logic [31:0] t;
        redir_tgt(kind, hit, t);
        if (hit) begin
            m_pend_v = 1'b1;
            m_pend_t = t;
        end
    endtask

    task automatic pick_kind(input bit rnd, input int fixed, output int kind);
        if (rnd) begin
            g_br_pc  = $urandom & 32'hFFFF_FFFC;
            g_br_imm = ($urandom_range(0, 7) == 0) ? 32'h0000_0002 : ($urandom & 32'hFFFF_FFFC);
            g_jt     = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
            kind     = $urandom_range(0, 8);
            if (kind > 4) kind = 0;
        end else begin
            kind = fixed;
        end
    endtask

    task automatic issue_phase(input int ready_wait, input bit rnd);
        int          k;
        int          kind;
        logic [31:0] hold;
        k = 0;
        while (imem_req_valid !== 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        chk1("req_valid_up", imem_req_valid, 1'b1);
        chk32("fetch_addr", imem_addr, m_pc);
        chk32("pc_out", pc, m_pc);
        hold = imem_addr;
        for (int i = 0; i < ready_wait; i++) begin
            pick_kind(rnd, 0, kind);
            drive_redir(kind);
            capture(kind);
            imem_rsp_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc();
            clear_redir();
            imem_rsp_valid = 1'b0;
            stall = 1'($urandom_range(0, 1));
            #1;
            chk1("req_valid_held", imem_req_valid, 1'b1);
            chk32("req_addr_stable", imem_addr, hold);
        end
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        stall = 1'b0;
        #1;
        chk1("wait_no_req", imem_req_valid, 1'b0);
    endtask

    task automatic fetch_txn(input int ready_wait, input int rsp_wait, input int wait_kind,
                             input int rsp_kind, input bit rnd, input bit pre_stall);
        int          kind;
        bit          hit;
        bit          used;
        logic [31:0] t;
        logic [31:0] nxt;
        issue_phase(ready_wait, rnd);
        for (int i = 0; i < rsp_wait; i++) begin
            pick_kind(rnd, wait_kind, kind);
            drive_redir(kind);
            capture(kind);
            cyc();
            clear_redir();
        end
        pick_kind(rnd, rsp_kind, kind);
        imem_rsp_valid = 1'b1;
        drive_redir(kind);
        redir_tgt(kind, hit, t);
        if (hit) begin
            nxt = t;  used = 1'b1;
        end else if (m_pend_v) begin
            nxt = m_pend_t;  used = 1'b1;
        end else begin
            nxt = m_pc + 32'd4;  used = 1'b0;
        end
        cyc();
        imem_rsp_valid = 1'b0;
        clear_redir();
        m_pend_v = 1'b0;
        if (nxt[1:0] != 2'b00) begin
            chk1("trap_entered", misalign_trap, 1'b1);
            chk32("trap_pc_hold", pc, m_pc);
            chk1("trap_no_flush", flush, 1'b0);
            chk1("trap_no_req", imem_req_valid, 1'b0);
            jalr_valid = 1'b1;  jalr_target = 32'h0000_4000;
            br_valid = 1'b1;  br_taken = 1'b1;  br_pc = 32'h40;  br_imm = 32'h0;
            cyc();
            clear_redir();
            chk1("trap_still", misalign_trap, 1'b1);
            chk32("trap_pc_still", pc, m_pc);
            trap_ack = 1'b1;
            cyc();
            trap_ack = 1'b0;
            m_pc = TRAP_VEC;
            chk32("trap_vec_pc", pc, m_pc);
            chk1("trap_ack_flush", flush, 1'b1);
            chk1("trap_cleared", misalign_trap, 1'b0);
        end else begin
            m_pc = nxt;
            chk32("next_pc", pc, m_pc);
            chk1("flush_on_update", flush, used);
            chk1("no_trap", misalign_trap, 1'b0);
        end
        stall = pre_stall;
        #1;
        chk1("issue_after_update", imem_req_valid, !pre_stall);
        cyc();
        chk1("flush_one_cycle", flush, 1'b0);
        stall = 1'b0;
    endtask

    initial begin
        m_pc = RESET_PC;  m_pend_v = 1'b0;  m_pend_t = 32'h0;
        g_br_pc = 32'h0;  g_br_imm = 32'h0;  g_jt = 32'h0;

        // Reset state and boot sequence
        cyc();
        cyc();
        chk32("reset_pc", pc, RESET_PC);
        chk1("reset_no_req", imem_req_valid, 1'b0);
        chk1("reset_no_flush", flush, 1'b0);
        chk1("reset_no_trap", misalign_trap, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("boot_no_req", imem_req_valid, 1'b0);
        cyc();
        chk1("req_after_boot", imem_req_valid, 1'b1);
        for (int i = 0; i < 3; i++) fetch_txn(0, 0, 0, 0, 1'b0, 1'b0);

        // Taken branch latched during WAIT_RSP: 0x100 + (-8)
        g_br_pc = 32'h0000_0100;  g_br_imm = 32'hFFFF_FFF8;
        fetch_txn(0, 1, 1, 0, 1'b0, 1'b0);
        chk32("branch_target", m_pc, 32'h0000_00F8);

        // JALR beats a same-cycle taken branch
        g_jt = 32'h0000_2001;  g_br_pc = 32'h0000_0040;  g_br_imm = 32'h0000_0010;
        fetch_txn(0, 0, 0, 4, 1'b0, 1'b1);

        // Wrap-around from the top of the address space
        g_jt = 32'hFFFF_FFFC;
        fetch_txn(0, 0, 0, 3, 1'b0, 1'b0);
        fetch_txn(0, 0, 0, 0, 1'b0, 1'b0);

        // Misaligned branch target traps, then vectors to TRAP_VEC
        g_jt = 32'h0000_0010;
        fetch_txn(0, 0, 0, 3, 1'b0, 1'b0);
        g_br_pc = 32'h0000_0010;  g_br_imm = 32'h0000_0002;
        fetch_txn(0, 0, 0, 1, 1'b0, 1'b0);

        // ready held low with stall toggling
        fetch_txn(3, 1, 0, 0, 1'b0, 1'b0);

        // Reset during WAIT_RSP with a redirect pending
        issue_phase(0, 1'b0);
        g_br_pc = 32'h0000_0200;  g_br_imm = 32'h0;
        drive_redir(1);
        cyc();
        clear_redir();
        rst_n = 1'b0;
        #1;
        chk32("async_reset_pc", pc, RESET_PC);
        chk1("async_reset_no_req", imem_req_valid, 1'b0);
        cyc();
        rst_n = 1'b1;
        m_pc = RESET_PC;  m_pend_v = 1'b0;
        #1;
        chk1("reboot_no_req", imem_req_valid, 1'b0);
        cyc();
        chk1("req_after_reboot", imem_req_valid, 1'b1);
        for (int i = 0; i < 3; i++) fetch_txn(0, 0, 0, 0, 1'b0, 1'b0);

        // Randomized fetches with redirects, stalls and backpressure
        for (int i = 0; i < 40; i++)
            fetch_txn($urandom_range(0, 3), $urandom_range(0, 2), 0, 0, 1'b1,
                      1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
